// File: rtl/key_conditioner.sv
// key_conditioner: synchronizes, debounces and edge-detects three active-low
// push-buttons (start, stop, show), producing debounced levels and one-cycle
// press pulses.
// Optional macro KEY_MUTEX_EN: when defined, coincident press pulses are
// reduced to the single highest-priority one (stop > start > show).

// One debounce channel: 2-flop synchronizer, stable level and hold counter.
module key_conditioner_lane #(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_level,
    output logic o_rise
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_lvl;

    // Debounce: count consecutive mismatches, accept the new level on the
    // DEB_CYCLES-th one; any matching sample restarts the count.
    always_comb begin
        sync_d   = {sync_q[0], i_key_n};
        key_lvl  = ~sync_q[1];
        stable_d = stable_q;
        cnt_d    = cnt_q;
        o_rise   = 1'b0;
        if (key_lvl == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = key_lvl;
            cnt_d    = '0;
            o_rise   = key_lvl;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers; reset loads the released (high) raw level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q   <= 2'b11;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_level = stable_q;
endmodule

module key_conditioner #(
    parameter int DEB_CYCLES = 500000,
    parameter int CNT_W      = 20
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] i_key_n,
    output logic       o_start,
    output logic       o_stop,
    output logic       o_show,
    output logic [2:0] o_key_level
);
    logic [2:0] rise;
    logic [2:0] pulse_q, pulse_d;

    for (genvar k = 0; k < 3; k++) begin : g_lane
        key_conditioner_lane #(
            .DEB_CYCLES(DEB_CYCLES),
            .CNT_W     (CNT_W)
        ) u_lane (
            .i_clk  (i_clk),
            .i_rst  (i_rst),
            .i_key_n(i_key_n[k]),
            .o_level(o_key_level[k]),
            .o_rise (rise[k])
        );
    end

    // Pulse selection; bit order is [0]=start, [1]=stop, [2]=show.
    always_comb begin
        pulse_d = rise;
`ifdef KEY_MUTEX_EN
        // Losers are dropped, not deferred.
        if (rise[1])      pulse_d = 3'b010;
        else if (rise[0]) pulse_d = 3'b001;
`endif
    end

    // Registered pulses line up with the stable-level update.
    always_ff @(posedge i_clk) begin
        if (i_rst) pulse_q <= '0;
        else       pulse_q <= pulse_d;
    end

    assign o_start = pulse_q[0];
    assign o_stop  = pulse_q[1];
    assign o_show  = pulse_q[2];
endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEB_CYCLES=4, CNT_W=4.
// Observed vector per cycle: {o_stop, o_start, o_show, o_key_level[2:0]}.
module tb_key_conditioner;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [2:0] i_key_n = 3'b111;
    logic       o_start, o_stop, o_show;
    logic [2:0] o_key_level;
    int         n_cmp = 0;
    int         n_err = 0;

    key_conditioner #(.DEB_CYCLES(4), .CNT_W(4)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_key_n    (i_key_n),
        .o_start    (o_start),
        .o_stop     (o_stop),
        .o_show     (o_show),
        .o_key_level(o_key_level)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [5:0] obs();
        return {o_stop, o_start, o_show, o_key_level};
    endfunction

    // Advance one edge and sample just after it.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        i_rst = 1'b1; i_key_n = 3'b000;
        for (int i = 0; i < 4; i++) begin
            step();
            got = obs(); n_cmp++;
            if (got !== 6'b0) begin
                n_err++; $display("FAIL reset[%0d]: got %b want %b", i, got, 6'b0);
            end
        end
        i_key_n = 3'b111;
        step();
        i_rst = 1'b0;
    endtask

    // Release all keys long enough for any level to drop; everything idle after.
    task automatic test_settle(input string tag);
        logic [5:0] got;
        i_key_n = 3'b111;
        for (int i = 0; i < 12; i++) step();
        got = obs(); n_cmp++;
        if (got !== 6'b0) begin
            n_err++; $display("FAIL settle_%s: got %b want %b", tag, got, 6'b0);
        end
    endtask

    // Press start sampled at edge N, held 20; then release held 12.
    task automatic test_clean_press();
        logic [5:0] got, exp;
        for (int i = 0; i < 32; i++) begin
            i_key_n = (i < 20) ? 3'b110 : 3'b111;
            step();
            exp = 6'b0;
            if (i == 5) exp[4] = 1'b1;
            if (i >= 5 && i < 25) exp[0] = 1'b1;
            got = obs(); n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL clean_press[%0d]: got %b want %b", i, got, exp);
            end
        end
    endtask

    // Stop key: low 3, high 1, low held; pulse at final falling sample + 5.
    task automatic test_bounce();
        logic [5:0] got, exp;
        for (int i = 0; i < 20; i++) begin
            i_key_n = (i == 3) ? 3'b111 : 3'b101;
            step();
            exp = 6'b0;
            if (i == 9) exp[5] = 1'b1;
            if (i >= 9) exp[1] = 1'b1;
            got = obs(); n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL bounce[%0d]: got %b want %b", i, got, exp);
            end
        end
    endtask

    // Show key glitch of DEB_CYCLES-1 samples: nothing must happen.
    task automatic test_glitch();
        logic [5:0] got;
        for (int i = 0; i < 12; i++) begin
            i_key_n = (i < 3) ? 3'b011 : 3'b111;
            step();
            got = obs(); n_cmp++;
            if (got !== 6'b0) begin
                n_err++; $display("FAIL glitch[%0d]: got %b want %b", i, got, 6'b0);
            end
        end
    endtask

    // Show: press 50, release 10, press 20 -> pulses at 5 and 65 only.
    task automatic test_repress();
        logic [5:0] got, exp;
        int pulses = 0;
        for (int i = 0; i < 80; i++) begin
            i_key_n = (i >= 50 && i < 60) ? 3'b111 : 3'b011;
            step();
            exp = 6'b0;
            if (i == 5 || i == 65) exp[3] = 1'b1;
            if ((i >= 5 && i < 55) || i >= 65) exp[2] = 1'b1;
            got = obs(); n_cmp++;
            if (o_show === 1'b1) pulses++;
            if (got !== exp) begin
                n_err++; $display("FAIL repress[%0d]: got %b want %b", i, got, exp);
            end
        end
        n_cmp++;
        if (pulses != 2) begin
            n_err++; $display("FAIL repress_count: got %0d want 2", pulses);
        end
    endtask

    // Start press; reset sampled at N+4 (count 2), R = N+5, pulse at N+10.
    task automatic test_reset_mid();
        logic [5:0] got, exp;
        for (int i = 0; i < 16; i++) begin
            i_key_n = 3'b110;
            i_rst = (i == 4);
            step();
            exp = 6'b0;
            if (i == 10) exp[4] = 1'b1;
            if (i >= 10) exp[0] = 1'b1;
            got = obs(); n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL reset_mid[%0d]: got %b want %b", i, got, exp);
            end
        end
        i_rst = 1'b0;
    endtask

    // Start and stop pressed on the same sample.
    task automatic test_coincident();
        logic [5:0] got, exp;
        for (int i = 0; i < 10; i++) begin
            i_key_n = 3'b100;
            step();
            exp = 6'b0;
            if (i == 5) begin
`ifdef KEY_MUTEX_EN
                exp[5] = 1'b1;
`else
                exp[5] = 1'b1; exp[4] = 1'b1;
`endif
            end
            if (i >= 5) exp[1:0] = 2'b11;
            got = obs(); n_cmp++;
            if (got !== exp) begin
                n_err++; $display("FAIL coincident[%0d]: got %b want %b", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_settle("init");
        test_clean_press();
        test_settle("clean");
        test_bounce();
        test_settle("bounce");
        test_glitch();
        test_repress();
        test_settle("repress");
        test_reset_mid();
        test_settle("reset_mid");
        test_coincident();
        test_settle("coincident");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 500000, meaning consecutive sampled cycles a new key level must hold before acceptance (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 20, meaning debounce counter width in bits.
REQ-003 Port i_clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port i_rst  input  1  reset, synchronous, active-high.
REQ-005 Port i_key_n  input  3  raw asynchronous push-buttons, active-low: [0]=start, [1]=stop, [2]=show.
REQ-006 Port o_start  output  1  one-cycle pulse per accepted start press, feeds the generator's i_start.
REQ-007 Port o_stop  output  1  one-cycle pulse per accepted stop press, feeds i_stop.
REQ-008 Port o_show  output  1  one-cycle pulse per accepted show press, feeds i_show.
REQ-009 Port o_key_level  output  3  debounced key levels, active-high (1 = pressed), same bit order as i_key_n.

Function
REQ-010 Each key SHALL pass through a 2-flop synchronizer and be inverted to active-high before any other use.
REQ-011 Per key, a stable-level register SHALL drive o_key_level; a counter SHALL clear in every cycle where the synchronized level equals the stable level.
REQ-012 When the synchronized level differs from stable, the counter SHALL increment; at the edge where a mismatch is seen with counter == DEB_CYCLES-1, stable SHALL take the synchronized level and the counter SHALL clear.
REQ-013 Latency: with raw press first sampled at edge N and held, stable and the pulse SHALL rise at edge N+DEB_CYCLES+1.
REQ-014 A pulse SHALL be registered only on a stable 0->1 transition; it SHALL be high for exactly one cycle.
REQ-015 Releases (stable 1->0) SHALL produce no pulse; release SHALL also require DEB_CYCLES mismatched samples.
REQ-016 A key held indefinitely SHALL produce exactly one pulse; a new pulse requires an accepted release, then an accepted press.
REQ-017 Any bounce or glitch lasting fewer than DEB_CYCLES consecutive samples SHALL clear the counter and produce no level change or pulse.
REQ-018 The three channels SHALL be fully independent except as modified by REQ-023.
REQ-019 Counter arithmetic SHALL never wrap; the counter SHALL not exceed DEB_CYCLES-1.

Reset
REQ-020 While i_rst is high at a clock edge: synchronizer flops SHALL load "released", stable levels 0, counters 0, o_start/o_stop/o_show 0, o_key_level 3'b000.
REQ-021 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be emitted for that edge.
REQ-022 A key held through reset SHALL be treated as a fresh press: with the first non-reset edge R, one pulse SHALL rise at edge R+DEB_CYCLES+1.

Configuration
REQ-023 Macro KEY_MUTEX_EN: when defined, if more than one pulse would fire in the same cycle, only the highest priority SHALL be emitted (stop > start > show) and the others SHALL be dropped, not deferred; when undefined, all coincident pulses SHALL be emitted together. o_key_level SHALL be unaffected either way.

Verification (DEB_CYCLES=4, CNT_W=4)
REQ-024 Clean press of i_key_n[0] first sampled at edge 10, held 20 cycles -> o_start high only after edge 15, o_key_level[0] rises at edge 15; no other outputs.
REQ-025 i_key_n[1] bounces low 3 cycles, high 1 cycle, then low and held -> exactly one o_stop pulse, 5 edges after the final falling sample; none before it.
REQ-026 Press i_key_n[2] held 50 cycles, release for 10 cycles, press again -> exactly two o_show pulses, no pulse on release.
REQ-027 i_rst asserted at count 2 of a start debounce, released one cycle later with key still low -> pulse at R+5 only, with R = first non-reset edge; all outputs 0 during reset.
REQ-028 Start and stop pressed on the same sample -> with KEY_MUTEX_EN defined, o_stop only; without it, o_start and o_stop together in the same cycle.
